// File: rtl/fuel_pkg.sv
// Shared types for the fuel-dispense controller: state codes, price width and output bundle.
// The registered outputs are derived from a state code by decode().
package fuel_pkg;

  localparam int PRICE_W    = 17;
  localparam int PRICE_STEP = 1000;
  localparam logic [PRICE_W-1:0] MAX_PRICE_DEFAULT = PRICE_W'(99 * PRICE_STEP);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PUMP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef struct packed {
    logic relay_auto;
    logic price_clear;
    logic busy;
    logic done;
    logic fault;
  } outs_t;

  function automatic outs_t decode(input state_t s);
    outs_t o;
    o             = '0;
    o.relay_auto  = (s == ST_PUMP);
    o.price_clear = (s == ST_CLEAR);
    o.busy        = (s == ST_CLEAR) || (s == ST_SETTLE) || (s == ST_PUMP);
    o.done        = (s == ST_DONE);
    o.fault       = (s == ST_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/input_conditioner.sv
// Two-flop synchroniser for an asynchronous panel/sensor pin; with EDGE=1 the output is a
// registered one-cycle pulse on each rising edge, otherwise the synchronised level.
module input_conditioner #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic out
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
    end
  end

  if (EDGE) begin : g_edge
    logic prev_q, pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        prev_q  <= sync_q;
        pulse_q <= sync_q & ~prev_q;
      end
    end

    assign out = pulse_q;
  end else begin : g_level
    assign out = sync_q;
  end

endmodule

// File: rtl/fuel_dispense_controller.sv
// Sequences one dispense: clear the price accumulator, settle the valve, pump until the
// accumulated price reaches the latched preset; stop button, tank-empty sensor and watchdog abort.
module fuel_dispense_controller
  import fuel_pkg::*;
#(
  parameter int                 CLEAR_CYCLES    = 2,
  parameter int                 SETTLE_CYCLES   = 1000,
  parameter logic [PRICE_W-1:0] MAX_PRICE       = MAX_PRICE_DEFAULT,
  parameter int                 MAX_PUMP_CYCLES = 120000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_req,
  input  logic               stop_req,
  input  logic               level_low,
  input  logic [PRICE_W-1:0] preset_price,
  input  logic [PRICE_W-1:0] price_mini,
  output logic               relay_auto,
  output logic               price_clear,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [2:0]         state_dbg
);

  localparam int CNT_MAX = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(MAX_PUMP_CYCLES + 1);

  logic start_pulse, stop_pulse, empty;

  input_conditioner #(.EDGE(1'b1)) u_start (.clk(clk), .rst_n(rst_n), .pin(start_req), .out(start_pulse));
  input_conditioner #(.EDGE(1'b1)) u_stop  (.clk(clk), .rst_n(rst_n), .pin(stop_req),  .out(stop_pulse));
  input_conditioner #(.EDGE(1'b0)) u_level (.clk(clk), .rst_n(rst_n), .pin(level_low), .out(empty));

  state_t             state;
  outs_t              outs;
  logic [CNT_W-1:0]   cnt;
  logic [WD_W-1:0]    wd;
  logic [PRICE_W-1:0] preset_q;
  logic               preset_ok;

  assign preset_ok = (preset_price != '0) && (preset_price <= MAX_PRICE);

  // NOTE: every transition writes state and its decoded outputs together with <=, so the
  // outputs are true registers that always agree with the state code they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      outs     <= '0;
      cnt      <= '0;
      wd       <= '0;
      preset_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A simultaneous stop edge suppresses the start.
          if (start_pulse && !stop_pulse) begin
            if (empty) begin
              state <= ST_FAULT;
              outs  <= decode(ST_FAULT);
            end else if (preset_ok) begin
              state    <= ST_CLEAR;
              outs     <= decode(ST_CLEAR);
              preset_q <= preset_price;
              cnt      <= CNT_W'(CLEAR_CYCLES - 1);
            end
          end
        end
        ST_CLEAR: begin
          if (stop_pulse) begin
            state <= ST_IDLE;
            outs  <= decode(ST_IDLE);
          end else if (cnt == '0) begin
            state <= ST_SETTLE;
            outs  <= decode(ST_SETTLE);
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (stop_pulse) begin
            state <= ST_IDLE;
            outs  <= decode(ST_IDLE);
          end else if (cnt == '0) begin
            // A non-zero price here means the calculator never cleared.
            state <= (price_mini != '0) ? ST_FAULT : ST_PUMP;
            outs  <= decode((price_mini != '0) ? ST_FAULT : ST_PUMP);
            wd    <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PUMP: begin
          if (empty) begin
            state <= ST_FAULT;
            outs  <= decode(ST_FAULT);
          end else if (stop_pulse || (price_mini >= preset_q)) begin
            state <= ST_DONE;
            outs  <= decode(ST_DONE);
          end else if (wd == WD_W'(MAX_PUMP_CYCLES - 1)) begin
            state <= ST_FAULT;
            outs  <= decode(ST_FAULT);
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_FAULT: begin
          if (stop_pulse && !empty) begin
            state <= ST_IDLE;
            outs  <= decode(ST_IDLE);
          end
        end
        default: begin
          state <= ST_IDLE;
          outs  <= decode(ST_IDLE);
        end
      endcase
    end
  end

  assign relay_auto  = outs.relay_auto;
  assign price_clear = outs.price_clear;
  assign busy        = outs.busy;
  assign done        = outs.done;
  assign fault       = outs.fault;
  assign state_dbg   = state;

endmodule
